// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between the fetch (I) and mem-stage (D) ports.
// One transaction at a time: arbitrate, wait for mem_gnt, then wait for mem_rvalid or a timeout.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,

    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    localparam int BE_W     = DATA_W / 8;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [TO_W-1:0]     TO_MAX     = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t              state;
    logic                owner_d;
    logic                hold_we;
    logic [BE_W-1:0]     hold_be;
    logic [ADDR_W-1:0]   hold_addr;
    logic [DATA_W-1:0]   hold_wdata;
    logic [STARVE_W-1:0] starve_cnt;
    logic [TO_W-1:0]     to_cnt;

    logic d_wins;
    logic in_req;
    logic gnt_evt;
    logic timed_out;
    logic resp;

    // D keeps priority until it has beaten a waiting fetch STARVE_LIMIT times in a row
    assign d_wins    = d_req && (!i_req || (starve_cnt < STARVE_MAX));
    assign in_req    = (state == REQ);
    assign gnt_evt   = in_req && mem_gnt;
    assign timed_out = (state == WAIT) && (to_cnt == TO_MAX);
    assign resp      = (state == WAIT) && (mem_rvalid || timed_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            hold_we    <= 1'b0;
            hold_be    <= '0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            starve_cnt <= '0;
            to_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner_d <= d_wins;
                        if (d_wins) begin
                            hold_we    <= d_we;
                            hold_be    <= d_be;
                            hold_addr  <= d_addr;
                            hold_wdata <= d_wdata;
                        end else begin
                            hold_we    <= 1'b0;
                            hold_be    <= '1;
                            hold_addr  <= i_addr;
                            hold_wdata <= '0;
                        end
                        if (i_req && d_wins) begin
                            if (starve_cnt != STARVE_MAX)
                                starve_cnt <= starve_cnt + STARVE_W'(1);
                        end else begin
                            starve_cnt <= '0;
                        end
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        to_cnt <= '0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid || timed_out)
                        state <= IDLE;
                    else
                        to_cnt <= to_cnt + TO_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req   = in_req;
    assign mem_we    = in_req && hold_we;
    assign mem_be    = in_req ? hold_be    : '0;
    assign mem_addr  = in_req ? hold_addr  : '0;
    assign mem_wdata = in_req ? hold_wdata : '0;

    assign i_gnt    = gnt_evt && !owner_d;
    assign d_gnt    = gnt_evt &&  owner_d;

    // A real response takes precedence over a timeout landing in the same cycle
    assign i_rvalid = resp && !owner_d;
    assign d_rvalid = resp &&  owner_d;
    assign i_err    = i_rvalid && !mem_rvalid;
    assign d_err    = d_rvalid && !mem_rvalid;
    assign i_rdata  = (i_rvalid && mem_rvalid) ? mem_rdata : '0;
    assign d_rdata  = (d_rvalid && mem_rvalid) ? mem_rdata : '0;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: inputs change on the falling edge, outputs
// are sampled 1 time unit later, well away from the rising (active) edge.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic              clk;
    logic              rst_n;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;
    logic              d_req;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;
    logic              mem_req;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int tests_run;
    int fail_count;

    logic any_out;
    logic any_d_out;
    assign any_out = |{i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
                       mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy};
    assign any_d_out = |{d_gnt, d_rvalid, d_rdata, d_err};

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++; if (any_out !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_outputs: got any=%0b want 0", any_out); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++; if (busy !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_busy_after_release: got %0b want 0", busy); end
    endtask

    task automatic test_fetch_read();
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0100;
        #1;
        tests_run++; if (mem_req !== 1'b0) begin fail_count++; $display("[TB] FAIL t1_idle_mem_req: got %0b want 0", mem_req); end
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        tests_run++; if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin fail_count++; $display("[TB] FAIL t1_mem_fields: got req=%0b we=%0b be=%h addr=%h want 1 0 f 00000100", mem_req, mem_we, mem_be, mem_addr); end
        tests_run++; if ({i_gnt, d_gnt} !== 2'b10) begin fail_count++; $display("[TB] FAIL t1_gnt: got i=%0b d=%0b want i=1 d=0", i_gnt, d_gnt); end
        @(negedge clk);
        i_req = 1'b0; mem_gnt = 1'b0;
        #1;
        tests_run++; if ({i_gnt, i_rvalid, mem_req, busy} !== 4'b0001) begin fail_count++; $display("[TB] FAIL t1_wait1: got gnt=%0b rv=%0b mreq=%0b busy=%0b want 0 0 0 1", i_gnt, i_rvalid, mem_req, busy); end
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        tests_run++; if ({i_rvalid, i_err, i_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin fail_count++; $display("[TB] FAIL t1_resp: got rv=%0b err=%0b rdata=%h want 1 0 deadbeef", i_rvalid, i_err, i_rdata); end
        tests_run++; if (any_d_out !== 1'b0) begin fail_count++; $display("[TB] FAIL t1_d_quiet: got any_d=%0b want 0", any_d_out); end
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        tests_run++; if ({busy, i_rvalid, i_rdata} !== 34'd0) begin fail_count++; $display("[TB] FAIL t1_idle_after: got busy=%0b rv=%0b rdata=%h want 0 0 0", busy, i_rvalid, i_rdata); end
    endtask

    task automatic test_data_write_delayed_gnt();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h0000_2004; d_wdata = 32'h0000_1234;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                d_addr = 32'h0000_9999; d_wdata = 32'hFFFF_FFFF;
            end
            mem_gnt = (c == 2);
            #1;
            tests_run++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h2004, 32'h1234}) begin fail_count++; $display("[TB] FAIL t2_mem_fields[%0d]: got req=%0b we=%0b be=%h addr=%h wdata=%h", c, mem_req, mem_we, mem_be, mem_addr, mem_wdata); end
            tests_run++; if (d_gnt !== (c == 2)) begin fail_count++; $display("[TB] FAIL t2_d_gnt[%0d]: got %0b want %0b", c, d_gnt, (c == 2)); end
        end
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b1;
        #1;
        tests_run++; if ({d_rvalid, d_err, i_rvalid} !== 3'b100) begin fail_count++; $display("[TB] FAIL t2_ack: got rv=%0b err=%0b i_rv=%0b want 1 0 0", d_rvalid, d_err, i_rvalid); end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0) begin fail_count++; $display("[TB] FAIL t2_idle_after: got busy=%0b want 0", busy); end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0200;
        d_req = 1'b1; d_addr = 32'h0000_3000; d_be = 4'hF;
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        tests_run++; if ({i_gnt, d_gnt, mem_addr} !== {2'b01, 32'h3000}) begin fail_count++; $display("[TB] FAIL t3_first_d: got i=%0b d=%0b addr=%h want 0 1 00003000", i_gnt, d_gnt, mem_addr); end
        @(negedge clk);
        d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0001;
        #1;
        tests_run++; if ({d_rvalid, d_rdata, i_rvalid} !== {1'b1, 32'hA5A5_0001, 1'b0}) begin fail_count++; $display("[TB] FAIL t3_d_resp: got rv=%0b rdata=%h i_rv=%0b", d_rvalid, d_rdata, i_rvalid); end
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        tests_run++; if ({i_gnt, d_gnt, mem_addr, mem_be} !== {2'b10, 32'h200, 4'hF}) begin fail_count++; $display("[TB] FAIL t3_then_i: got i=%0b d=%0b addr=%h be=%h", i_gnt, d_gnt, mem_addr, mem_be); end
        @(negedge clk);
        i_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_CAFE;
        #1;
        tests_run++; if ({i_rvalid, i_rdata, d_rvalid} !== {1'b1, 32'h0BAD_CAFE, 1'b0}) begin fail_count++; $display("[TB] FAIL t3_i_resp: got rv=%0b rdata=%h d_rv=%0b", i_rvalid, i_rdata, d_rvalid); end
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    // Starvation counter is 0 here after the I win above, so order must be D,D,D,D,I,D
    task automatic test_starvation();
        logic [1:0] want;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0400;
        d_req = 1'b1; d_addr = 32'h0000_5000; d_we = 1'b0; d_be = 4'hF;
        for (int g = 0; g < 6; g++) begin
            want = (g == 4) ? 2'b10 : 2'b01;
            @(negedge clk);
            mem_gnt = 1'b1;
            #1;
            tests_run++; if ({i_gnt, d_gnt} !== want) begin fail_count++; $display("[TB] FAIL t4_order[%0d]: got i=%0b d=%0b want i=%0b d=%0b", g, i_gnt, d_gnt, want[1], want[0]); end
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b1;
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (g == 5) begin
                i_req = 1'b0; d_req = 1'b0;
            end
        end
        #1;
        tests_run++; if (busy !== 1'b0) begin fail_count++; $display("[TB] FAIL t4_idle_after: got busy=%0b want 0", busy); end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_6000; d_be = 4'hF;
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        tests_run++; if (d_gnt !== 1'b1) begin fail_count++; $display("[TB] FAIL t5_gnt: got %0b want 1", d_gnt); end
        @(negedge clk);
        d_req = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'h0000_0BAD;
        for (int k = 0; k < 255; k++) begin
            #1;
            if (d_rvalid || d_err) early++;
            @(negedge clk);
        end
        tests_run++; if (early !== 0) begin fail_count++; $display("[TB] FAIL t5_no_early_resp: got %0d cycles with response want 0", early); end
        #1;
        tests_run++; if ({d_rvalid, d_err, d_rdata, i_rvalid, busy} !== {1'b1, 1'b1, 32'd0, 1'b0, 1'b1}) begin fail_count++; $display("[TB] FAIL t5_timeout_resp: got rv=%0b err=%0b rdata=%h i_rv=%0b busy=%0b want 1 1 0 0 1", d_rvalid, d_err, d_rdata, i_rvalid, busy); end
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        #1;
        tests_run++; if ({busy, d_rvalid, d_err, d_rdata, i_rvalid, i_rdata} !== 68'd0) begin fail_count++; $display("[TB] FAIL t5_stray_dropped: got busy=%0b d_rv=%0b d_err=%0b d_rdata=%h i_rv=%0b", busy, d_rvalid, d_err, d_rdata, i_rvalid); end
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        tests_run++; if (busy !== 1'b0) begin fail_count++; $display("[TB] FAIL t5_still_idle: got busy=%0b want 0", busy); end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0800;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        i_req = 1'b0; mem_gnt = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b1) begin fail_count++; $display("[TB] FAIL t6_in_wait: got busy=%0b want 1", busy); end
        #1;
        rst_n = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
        #1;
        tests_run++; if (any_out !== 1'b0) begin fail_count++; $display("[TB] FAIL t6_async_clear: got any=%0b busy=%0b i_rv=%0b want 0", any_out, busy, i_rvalid); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++; if ({busy, i_rvalid, i_rdata, i_err} !== 35'd0) begin fail_count++; $display("[TB] FAIL t6_late_rvalid: got busy=%0b rv=%0b rdata=%h err=%0b want 0", busy, i_rvalid, i_rdata, i_err); end
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        tests_run++; if (any_out !== 1'b0) begin fail_count++; $display("[TB] FAIL t6_idle_after: got any=%0b want 0", any_out); end
    endtask

    initial begin
        tests_run  = 0;
        fail_count = 0;
        test_reset();
        test_fetch_read();
        test_data_write_delayed_gnt();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
